uart_tx_fifo_reader: RTL and testbench
======================================

# uart_tx_fifo_reader

- Serial transmit engine that drains bytes from an upstream `fifo` instance through that FIFO's read side (`data_out`, `data_out_valid`, `pop`).
- Emits each word on a UART line as 8N1-style frames: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
- Sits between the CPU-side TX FIFO and the board UART pin.
- Frames are issued back-to-back with no idle gap while the FIFO is non-empty and transmission is enabled.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per frame; must equal the upstream FIFO_WIDTH.
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range ≥ 2.
- STOP_BITS, 1, number of stop bit periods; legal values 1 or 2.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- fifo_data  input  DATA_WIDTH  upstream FIFO `data_out`; valid whenever fifo_valid=1.
- fifo_valid  input  1  upstream FIFO `data_out_valid` (i.e. not empty).
- fifo_pop  output  1  one-cycle pop strobe to the upstream FIFO `pop`.
- tx_enable  input  1  when 0, no new frame starts; a frame in progress completes.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, STOP.
- Counters:
  - baud_cnt, $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1.
  - bit_cnt, $clog2(DATA_WIDTH) bits, data bit index.
  - stop_cnt, 1 bit.
- take = tx_enable & fifo_valid & (state==IDLE | last_stop_cycle) & !reset.
  - last_stop_cycle = state==STOP, baud_cnt==CLKS_PER_BIT-1, stop_cnt==STOP_BITS-1.
- fifo_pop = take.
  - Combinational from registered state plus inputs; no other path asserts it.
- When take=1:
  - shift register loads fifo_data at the same clock edge.
  - Next state is START with baud_cnt=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_cnt=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit end. After bit DATA_WIDTH-1, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At last_stop_cycle, go to START if take, else IDLE.
- busy=1 in START/DATA/STOP, 0 in IDLE.
- tx is registered, driven from next-state logic so line transitions align with state entry.
- A frame in progress always completes regardless of fifo_valid or tx_enable changes.

## Timing
- Reset values: state IDLE, tx=1, busy=0, fifo_pop=0, counters 0, shift register 0.
- Latency: fifo_pop high in cycle T, so tx=0 and busy=1 from cycle T+1.
- Frame length: exactly (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
  - Back-to-back frame period equals this length.
  - The next start bit begins the cycle after the last stop cycle.
- One pop per frame; fifo_pop is never high on two consecutive cycles when CLKS_PER_BIT ≥ 2.
- fifo_valid=0 in IDLE: no pop, tx stays 1.
- fifo_valid rising in the last stop cycle counts for back-to-back.
- tx_enable=0 in the last stop cycle: go to IDLE; resume when enable returns.
- Reset mid-frame:
  - tx=1, busy=0 the cycle after reset is sampled.
  - The popped word is discarded, not re-popped.
- Reset concurrent with fifo_valid=1: fifo_pop=0 during reset cycles.

## Test plan
- CLKS_PER_BIT=4, STOP_BITS=1, FIFO holds 0xA5, tx_enable=1 → fifo_pop for 1 cycle. tx from next cycle, 4 cycles each: 0, then 1,0,1,0,0,1,0,1, then 1. busy high exactly 40 cycles, then tx=1 idle.
- FIFO holds 0x00 then 0xFF, CLKS_PER_BIT=4 → second fifo_pop exactly 40 cycles after the first. Second start bit immediately follows the first stop bit; tx is 1 for only 4 cycles between frames.
- STOP_BITS=2, one byte 0x3C → stop high 8 cycles; busy 44 cycles total.
- tx_enable=0 with FIFO non-empty → no fifo_pop, tx=1 for 100 cycles.
  - Enable drop mid-frame of a 2-byte burst → first frame completes, second not popped until enable returns.
- reset asserted at cycle 10 of a frame → tx=1, busy=0, fifo_pop=0 next cycle. After release with FIFO still non-empty, next word popped 1 cycle later and framed correctly.
- Empty FIFO for 200 cycles → fifo_pop never asserted, tx=1, busy=0. A push then yields a pop in the cycle fifo_valid first reads 1.

Source files
------------

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains words from an upstream FIFO read port.
// Frames are start, DATA_WIDTH data bits LSB first, then STOP_BITS stop bits.
module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_pop,
    input  logic                  tx_enable,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         baud_q;
    logic [IW-1:0]         bit_q;
    logic                  stop_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  tx_q;
    logic                  busy_q;

    logic baud_end;
    logic last_stop;
    logic take;

    assign baud_end  = (baud_q == BAUD_LAST);
    assign last_stop = (state_q == STOP) && baud_end && (stop_q == STOP_LAST);
    assign take      = tx_enable & fifo_valid & ~reset
                     & ((state_q == IDLE) | last_stop);
    assign shift_d   = shift_q >> 1;

    assign fifo_pop = take;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // A take in the last stop cycle chains straight into the next start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (take) begin
            state_q <= START;
            baud_q  <= '0;
            shift_q <= fifo_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                START: begin
                    if (baud_end) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= shift_d;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                            stop_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + IW'(1);
                            tx_q  <= shift_d[0];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (stop_q == STOP_LAST) begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: two instances (one and two stop bits),
// FIFO models and per-cycle logs decoded against an expected-byte queue.
module tb_uart_tx_fifo_reader;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en1 = 1'b0;
    logic en2 = 1'b0;
    logic [7:0] fd1, fd2;
    logic fv1, fv2, fp1, fp2, tx1, tx2, bz1, bz2;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .fifo_data(fd1), .fifo_valid(fv1),
        .fifo_pop(fp1), .tx_enable(en1), .tx(tx1), .busy(bz1)
    );

    uart_tx_fifo_reader #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .reset(reset), .fifo_data(fd2), .fifo_valid(fv2),
        .fifo_pop(fp2), .tx_enable(en2), .tx(tx2), .busy(bz2)
    );

    // Upstream FIFO models: writes from the stimulus, reads on fifo_pop.
    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [3:0] wr1 = '0, rd1 = '0, wr2 = '0, rd2 = '0;

    assign fv1 = (wr1 != rd1);
    assign fd1 = mem1[rd1];
    assign fv2 = (wr2 != rd2);
    assign fd2 = mem2[rd2];

    always @(posedge clk) begin
        if (fp1 === 1'b1) rd1 <= rd1 + 4'd1;
        if (fp2 === 1'b1) rd2 <= rd2 + 4'd1;
    end

    logic [7:0] exp1 [$];
    logic [7:0] exp2 [$];

    logic ltx1 [256];
    logic lbz1 [256];
    logic lpp1 [256];
    logic ltx2 [256];
    logic lbz2 [256];
    logic lpp2 [256];

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] got;
    logic [7:0] want;
    int c;

    task automatic push1(input logic [7:0] b);
        mem1[wr1] = b;
        wr1 = wr1 + 4'd1;
        exp1.push_back(b);
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2] = b;
        wr2 = wr2 + 4'd1;
        exp2.push_back(b);
    endtask

    // kind 1: drop en1 after cycle at; kind 2: one-cycle reset after cycle at
    task automatic run(input int n, input int at, input int kind);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ltx1[i] = tx1; lbz1[i] = bz1; lpp1[i] = fp1;
            ltx2[i] = tx2; lbz2[i] = bz2; lpp2[i] = fp2;
            @(posedge clk);
            #1;
            if (kind == 1 && i == at) en1 = 1'b0;
            if (kind == 2 && i == at) reset = 1'b1;
            if (kind == 2 && i == at + 1) reset = 1'b0;
        end
    endtask

    // sel: 0 pop1, 1 busy1, 2 tx1 not high, 3 pop2, 4 busy2, 5 tx2 not high
    function automatic int cnt(input int sel, input int lo, input int hi);
        int k = 0;
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: k += int'(lpp1[i] === 1'b1);
                1: k += int'(lbz1[i] === 1'b1);
                2: k += int'(ltx1[i] !== 1'b1);
                3: k += int'(lpp2[i] === 1'b1);
                4: k += int'(lbz2[i] === 1'b1);
                default: k += int'(ltx2[i] !== 1'b1);
            endcase
        end
        return k;
    endfunction

    function automatic logic [7:0] byte_at(input int d, input int p);
        logic [7:0] b;
        int idx;
        for (int k = 0; k < 8; k++) begin
            idx = p + 1 + (k + 1) * CPB + CPB / 2;
            b[k] = (d == 1) ? ltx1[idx] : ltx2[idx];
        end
        return b;
    endfunction

    function automatic int wave_err(input int d, input int p,
                                    input logic [7:0] b, input int sb);
        int k = 0;
        int bi;
        logic e, o;
        for (int i = 0; i < (9 + sb) * CPB; i++) begin
            bi = i / CPB;
            if (bi == 0) e = 1'b0;
            else if (bi <= 8) e = b[bi-1];
            else e = 1'b1;
            o = (d == 1) ? ltx1[p+1+i] : ltx2[p+1+i];
            if (o !== e) k++;
        end
        return k;
    endfunction

    task automatic test_reset();
        en1 = 1'b1;
        en2 = 1'b1;
        push1(8'hA5);
        run(3, 0, 0);
        n_cmp++; c = cnt(0, 0, 2);
        if (c != 0) begin n_err++; $display("FAIL rst_pop: got %0d pops exp 0", c); end
        n_cmp++; c = cnt(2, 0, 2);
        if (c != 0) begin n_err++; $display("FAIL rst_tx: got %0d low exp 0", c); end
        n_cmp++; c = cnt(1, 0, 2);
        if (c != 0) begin n_err++; $display("FAIL rst_busy: got %0d busy exp 0", c); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        run(50, 0, 0);
        n_cmp++;
        if (lpp1[0] !== 1'b1) begin n_err++; $display("FAIL single_pop0: got %b exp 1", lpp1[0]); end
        n_cmp++; c = cnt(0, 0, 49);
        if (c != 1) begin n_err++; $display("FAIL single_npop: got %0d exp 1", c); end
        n_cmp++; c = cnt(1, 1, 40);
        if (c != 40) begin n_err++; $display("FAIL single_busy: got %0d exp 40", c); end
        n_cmp++; c = cnt(1, 41, 49) + cnt(2, 41, 49);
        if (c != 0) begin n_err++; $display("FAIL single_idle: got %0d exp 0", c); end
        want = exp1.pop_front();
        n_cmp++; c = wave_err(1, 0, want, 1);
        if (c != 0) begin n_err++; $display("FAIL single_wave: got %0d bad exp 0", c); end
        n_cmp++; got = byte_at(1, 0);
        if (got !== want) begin n_err++; $display("FAIL single_byte: got %h exp %h", got, want); end
    endtask

    task automatic test_back_to_back();
        push1(8'h00);
        push1(8'hFF);
        run(100, 0, 0);
        n_cmp++; c = cnt(0, 0, 99);
        if (c != 2 || lpp1[40] !== 1'b1) begin n_err++; $display("FAIL b2b_pop: got %0d pops exp 2 at 0,40", c); end
        n_cmp++; c = cnt(1, 1, 80);
        if (c != 80 || lbz1[81] !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %0d exp 80", c); end
        n_cmp++; c = cnt(2, 37, 40);
        if (ltx1[36] !== 1'b0 || c != 0 || ltx1[41] !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %0d low exp 0", c); end
        for (int f = 0; f < 2; f++) begin
            want = exp1.pop_front();
            n_cmp++; c = wave_err(1, f * 40, want, 1);
            if (c != 0) begin n_err++; $display("FAIL b2b_wave%0d: got %0d bad exp 0", f, c); end
            n_cmp++; got = byte_at(1, f * 40);
            if (got !== want) begin n_err++; $display("FAIL b2b_byte%0d: got %h exp %h", f, got, want); end
        end
    endtask

    task automatic test_two_stop();
        push2(8'h3C);
        run(60, 0, 0);
        n_cmp++;
        if (lpp2[0] !== 1'b1) begin n_err++; $display("FAIL stop2_pop: got %b exp 1", lpp2[0]); end
        n_cmp++; c = cnt(4, 0, 59);
        if (c != 44) begin n_err++; $display("FAIL stop2_busy: got %0d exp 44", c); end
        n_cmp++; c = cnt(5, 37, 59);
        if (c != 0) begin n_err++; $display("FAIL stop2_high: got %0d low exp 0", c); end
        want = exp2.pop_front();
        n_cmp++; c = wave_err(2, 0, want, 2);
        if (c != 0) begin n_err++; $display("FAIL stop2_wave: got %0d bad exp 0", c); end
        n_cmp++; got = byte_at(2, 0);
        if (got !== want) begin n_err++; $display("FAIL stop2_byte: got %h exp %h", got, want); end
    endtask

    task automatic test_enable();
        en1 = 1'b0;
        push1(8'h5A);
        push1(8'hC3);
        run(100, 0, 0);
        n_cmp++; c = cnt(0, 0, 99) + cnt(1, 0, 99);
        if (c != 0) begin n_err++; $display("FAIL en_off_pop: got %0d exp 0", c); end
        n_cmp++; c = cnt(2, 0, 99);
        if (c != 0) begin n_err++; $display("FAIL en_off_tx: got %0d low exp 0", c); end
        en1 = 1'b1;
        run(100, 20, 1);
        n_cmp++; c = cnt(0, 0, 99);
        if (c != 1 || lpp1[0] !== 1'b1) begin n_err++; $display("FAIL en_drop_pop: got %0d exp 1", c); end
        n_cmp++; c = cnt(1, 0, 99);
        if (c != 40) begin n_err++; $display("FAIL en_drop_busy: got %0d exp 40", c); end
        want = exp1.pop_front();
        n_cmp++; got = byte_at(1, 0);
        if (got !== want) begin n_err++; $display("FAIL en_drop_byte: got %h exp %h", got, want); end
        n_cmp++; c = cnt(2, 41, 99);
        if (c != 0) begin n_err++; $display("FAIL en_drop_idle: got %0d low exp 0", c); end
        en1 = 1'b1;
        run(50, 0, 0);
        n_cmp++;
        if (lpp1[0] !== 1'b1) begin n_err++; $display("FAIL en_resume_pop: got %b exp 1", lpp1[0]); end
        want = exp1.pop_front();
        n_cmp++; c = wave_err(1, 0, want, 1);
        if (c != 0) begin n_err++; $display("FAIL en_resume_wave: got %0d bad exp 0", c); end
    endtask

    task automatic test_reset_mid();
        push1(8'h96);
        push1(8'h69);
        run(60, 10, 2);
        n_cmp++;
        if (lpp1[0] !== 1'b1 || lpp1[11] !== 1'b0) begin n_err++; $display("FAIL rmid_pop: got %b%b exp 10", lpp1[0], lpp1[11]); end
        n_cmp++;
        if (ltx1[12] !== 1'b1 || lbz1[12] !== 1'b0) begin n_err++; $display("FAIL rmid_line: got tx %b busy %b exp 1 0", ltx1[12], lbz1[12]); end
        n_cmp++; c = cnt(0, 0, 59);
        if (c != 2 || lpp1[12] !== 1'b1) begin n_err++; $display("FAIL rmid_repop: got %0d exp 2", c); end
        void'(exp1.pop_front());
        want = exp1.pop_front();
        n_cmp++; got = byte_at(1, 12);
        if (got !== want) begin n_err++; $display("FAIL rmid_byte: got %h exp %h", got, want); end
        n_cmp++; c = wave_err(1, 12, want, 1);
        if (c != 0 || lbz1[53] !== 1'b0) begin n_err++; $display("FAIL rmid_wave: got %0d bad exp 0", c); end
    endtask

    task automatic test_empty();
        run(200, 0, 0);
        n_cmp++; c = cnt(0, 0, 199) + cnt(1, 0, 199) + cnt(2, 0, 199);
        if (c != 0) begin n_err++; $display("FAIL empty_idle: got %0d events exp 0", c); end
        push1(8'hE7);
        #1;
        n_cmp++;
        if (fp1 !== 1'b1) begin n_err++; $display("FAIL empty_push_pop: got %b exp 1", fp1); end
        run(50, 0, 0);
        want = exp1.pop_front();
        n_cmp++; got = byte_at(1, 0);
        if (got !== want) begin n_err++; $display("FAIL empty_byte: got %h exp %h", got, want); end
        n_cmp++; c = exp1.size() + exp2.size();
        if (c != 0) begin n_err++; $display("FAIL sb_left: got %0d exp 0", c); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop();
        test_enable();
        test_reset_mid();
        test_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
